// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-stage types: default datapath widths and the buffered {pc, instr} entry.
package fetch_pkg;

    localparam int DEF_PC_WIDTH    = 16;
    localparam int DEF_INSTR_WIDTH = 32;

    typedef struct packed {
        logic [DEF_PC_WIDTH-1:0]    pc;
        logic [DEF_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: PC handshake, instruction-memory request/response and decode handshake.
interface instr_fetch_queue_if #(
    parameter int PC_WIDTH    = fetch_pkg::DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = fetch_pkg::DEF_INSTR_WIDTH
);

    logic [PC_WIDTH-1:0]    pc_in;
    logic                   pc_en;
    logic                   flush;
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_gnt;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;
    logic                   id_valid;
    logic [INSTR_WIDTH-1:0] id_instr;
    logic [PC_WIDTH-1:0]    id_pc;
    logic                   id_ready;

    modport master (
        input  pc_in, flush, imem_gnt, imem_rsp_valid, imem_rsp_data, id_ready,
        output pc_en, imem_req, imem_addr, id_valid, id_instr, id_pc
    );

    modport slave (
        output pc_in, flush, imem_gnt, imem_rsp_valid, imem_rsp_data, id_ready,
        input  pc_en, imem_req, imem_addr, id_valid, id_instr, id_pc
    );

endinterface

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Small synchronous FIFO with registered storage, clear, and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (int'(ptr) == DEPTH - 1) ? '0 : ptr + AW'(1);
    endfunction

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // NOTE: storage has no reset; a slot is only read after it was written, so resetting pointers suffices.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues in-order imem requests at the PC, buffers {pc,instr} for decode, drops work on flush.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH        = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH     = DEF_INSTR_WIDTH,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic                 clk,
    input logic                 rst,
    instr_fetch_queue_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [OUT_W-1:0]    r_outstanding;
    logic [OUT_W-1:0]    r_drop;
    logic [CNT_W-1:0]    w_count;
    logic [OUT_W-1:0]    w_tag_count;
    logic [PC_WIDTH-1:0] w_tag_pc;
    logic                w_tag_full;
    logic                w_tag_empty;
    logic                w_full;
    logic                w_empty;
    logic                w_req;
    logic                w_accept;
    logic                w_rsp;
    logic                w_push;
    logic                w_pop;
    fetch_entry_t        w_push_entry;
    fetch_entry_t        w_head;

    // Reserving a FIFO slot per in-flight request means responses never need back-pressure.
    assign w_req = rst && !bus.flush
                && (int'(r_outstanding) < MAX_OUTSTANDING)
                && (int'(w_count) + int'(r_outstanding) < DEPTH);

    assign w_accept     = w_req && bus.imem_gnt;
    assign w_rsp        = bus.imem_rsp_valid;
    assign w_push       = w_rsp && !bus.flush && (r_drop == '0);
    assign w_pop        = !w_empty && bus.id_ready && !bus.flush;
    assign w_push_entry = '{pc: w_tag_pc, instr: bus.imem_rsp_data};

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = bus.pc_in;
    assign bus.pc_en     = w_accept;
    assign bus.id_valid  = !w_empty;
    assign bus.id_pc     = w_empty ? '0 : w_head.pc;
    assign bus.id_instr  = w_empty ? '0 : w_head.instr;

    sync_fifo #(.WIDTH(PC_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
        .clk  (clk),
        .rst  (rst),
        .push (w_accept),
        .pop  (w_rsp),
        .clear(1'b0),
        .din  (bus.pc_in),
        .dout (w_tag_pc),
        .full (w_tag_full),
        .empty(w_tag_empty),
        .count(w_tag_count)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_q (
        .clk  (clk),
        .rst  (rst),
        .push (w_push),
        .pop  (w_pop),
        .clear(bus.flush),
        .din  (w_push_entry),
        .dout (w_head),
        .full (w_full),
        .empty(w_empty),
        .count(w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= r_outstanding + OUT_W'(w_accept) - OUT_W'(w_rsp);
            // Every request in flight at a redirect predates it, and drop already counts a subset of them.
            if (bus.flush)
                r_drop <= r_outstanding - OUT_W'(w_rsp);
            else if (w_rsp && r_drop != '0)
                r_drop <= r_drop - OUT_W'(1);
        end
    end

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst)
        w_rsp |-> (r_outstanding != '0) && !w_tag_empty);
    a_entry_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        w_push |-> !w_full);
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        w_accept |-> !w_tag_full);
    a_drop_bounded: assert property (@(posedge clk) disable iff (!rst)
        r_drop <= r_outstanding);
    a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (!rst)
        w_tag_count == r_outstanding);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, back-pressure, latency, flush and async reset.
module tb_instr_fetch_queue;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    instr_fetch_queue_if bus ();

    instr_fetch_queue u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [15:0] pc);
        return {16'hC0DE, pc};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs shortly after the rising edge, then settle before checks.
    task automatic drive(input logic [15:0] pc, input logic gnt, input logic rsp_v,
                         input logic [15:0] rsp_pc, input logic ready, input logic fl);
        bus.pc_in          = pc;
        bus.imem_gnt       = gnt;
        bus.imem_rsp_valid = rsp_v;
        bus.imem_rsp_data  = rsp_v ? ins(rsp_pc) : 32'h0;
        bus.id_ready       = ready;
        bus.flush          = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] drain_pc [4];
        drain_pc[0] = 16'h0000;
        drain_pc[1] = 16'h0004;
        drain_pc[2] = 16'h0008;
        drain_pc[3] = 16'h000C;

        // Reset: outputs quiet even with grant and ready asserted.
        rst = 1'b0;
        drive(16'h0000, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        check("rst req",      bus.imem_req, 0);
        check("rst pc_en",    bus.pc_en,    0);
        check("rst id_valid", bus.id_valid, 0);
        check("rst id_pc",    bus.id_pc,    0);
        check("rst id_instr", bus.id_instr, 0);
        tick();
        tick();
        rst = 1'b1;

        // 1: streaming, 1-cycle responses, decode always ready.
        drive(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t1 req c0",   bus.imem_req,  1);
        check("t1 pc_en c0", bus.pc_en,     1);
        check("t1 addr c0",  bus.imem_addr, 16'h0000);
        tick();
        drive(16'h0004, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        check("t1 pc_en c1", bus.pc_en,    1);
        check("t1 valid c1", bus.id_valid, 0);
        tick();
        drive(16'h0008, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b0);
        check("t1 pc_en c2", bus.pc_en,    1);
        check("t1 valid c2", bus.id_valid, 1);
        check("t1 pc c2",    bus.id_pc,    16'h0000);
        check("t1 instr c2", bus.id_instr, ins(16'h0000));
        tick();
        drive(16'h0008, 1'b0, 1'b1, 16'h0008, 1'b1, 1'b0);
        check("t1 pc c3", bus.id_pc, 16'h0004);
        tick();
        drive(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t1 valid c4", bus.id_valid, 1);
        check("t1 pc c4",    bus.id_pc,    16'h0008);
        tick();
        drive(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t1 valid c5", bus.id_valid, 0);
        tick();

        // 2: decode stalled fills all four entries, then issue stops; drain in order.
        drive(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
        drive(16'h0004, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0); tick();
        drive(16'h0008, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b0); tick();
        drive(16'h000C, 1'b1, 1'b1, 16'h0008, 1'b0, 1'b0); tick();
        drive(16'h0010, 1'b1, 1'b1, 16'h000C, 1'b0, 1'b0);
        check("t2 req slots reserved",   bus.imem_req, 0);
        check("t2 pc_en slots reserved", bus.pc_en,    0);
        tick();
        drive(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t2 req full",   bus.imem_req, 0);
        check("t2 pc_en full", bus.pc_en,    0);
        check("t2 valid full", bus.id_valid, 1);
        check("t2 head full",  bus.id_pc,    16'h0000);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
            check($sformatf("t2 drain valid %0d", i), bus.id_valid, 1);
            check($sformatf("t2 drain pc %0d", i),    bus.id_pc,    drain_pc[i]);
            tick();
        end
        drive(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t2 drained", bus.id_valid, 0);
        tick();

        // 3: 3-cycle latency caps in-flight requests at two.
        drive(16'h0020, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t3 pc_en g0", bus.pc_en, 1);
        tick();
        drive(16'h0024, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t3 pc_en g1", bus.pc_en, 1);
        tick();
        drive(16'h0028, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t3 req at max c2",   bus.imem_req, 0);
        check("t3 pc_en at max c2", bus.pc_en,    0);
        tick();
        drive(16'h0028, 1'b1, 1'b1, 16'h0020, 1'b1, 1'b0);
        check("t3 req at max c3", bus.imem_req, 0);
        tick();
        drive(16'h0028, 1'b1, 1'b1, 16'h0024, 1'b1, 1'b0);
        check("t3 pc_en resume", bus.pc_en, 1);
        check("t3 pc c4",        bus.id_pc, 16'h0020);
        tick();
        drive(16'h002C, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t3 pc c5", bus.id_pc, 16'h0024);
        tick();
        drive(16'h002C, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t3 gap c6", bus.id_valid, 0);
        tick();
        drive(16'h002C, 1'b0, 1'b1, 16'h0028, 1'b1, 1'b0); tick();
        drive(16'h002C, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t3 pc c8", bus.id_pc, 16'h0028);
        tick();

        // 4: flush with two buffered and two in flight; both late responses dropped.
        drive(16'h0030, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
        drive(16'h0034, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
        drive(16'h0038, 1'b1, 1'b1, 16'h0030, 1'b0, 1'b0);
        check("t4 req c2", bus.imem_req, 0);
        tick();
        drive(16'h0038, 1'b1, 1'b1, 16'h0034, 1'b0, 1'b0);
        check("t4 pc_en c3", bus.pc_en, 1);
        tick();
        drive(16'h003C, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t4 pc_en c4", bus.pc_en, 1);
        tick();
        drive(16'h0040, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        check("t4 req flush",   bus.imem_req, 0);
        check("t4 pc_en flush", bus.pc_en,    0);
        check("t4 head before", bus.id_pc,    16'h0030);
        tick();
        drive(16'h0040, 1'b1, 1'b1, 16'h0038, 1'b0, 1'b0);
        check("t4 valid after flush", bus.id_valid, 0);
        check("t4 req still max",     bus.imem_req, 0);
        tick();
        drive(16'h0040, 1'b1, 1'b1, 16'h003C, 1'b0, 1'b0);
        check("t4 pc_en new pc", bus.pc_en,     1);
        check("t4 addr new pc",  bus.imem_addr, 16'h0040);
        check("t4 drop 1",       bus.id_valid,  0);
        tick();
        drive(16'h0044, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b0);
        check("t4 drop 2", bus.id_valid, 0);
        tick();
        drive(16'h0044, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t4 new valid", bus.id_valid, 1);
        check("t4 new pc",    bus.id_pc,    16'h0040);
        check("t4 new instr", bus.id_instr, ins(16'h0040));
        tick();
        drive(16'h0044, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t4 empty", bus.id_valid, 0);
        tick();

        // 5: flush coincides with a response and a grant; only one later response dropped.
        drive(16'h0050, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0); tick();
        drive(16'h0054, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t5 pc_en c1", bus.pc_en, 1);
        tick();
        drive(16'h0080, 1'b1, 1'b1, 16'h0050, 1'b1, 1'b1);
        check("t5 req flush",   bus.imem_req, 0);
        check("t5 pc_en flush", bus.pc_en,    0);
        tick();
        drive(16'h0080, 1'b0, 1'b1, 16'h0054, 1'b1, 1'b0);
        check("t5 flush rsp dropped", bus.id_valid, 0);
        check("t5 req resumes",       bus.imem_req, 1);
        tick();
        drive(16'h0080, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t5 late rsp dropped", bus.id_valid, 0);
        check("t5 pc_en new",        bus.pc_en,    1);
        tick();
        drive(16'h0084, 1'b0, 1'b1, 16'h0080, 1'b1, 1'b0); tick();
        drive(16'h0084, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t5 new valid", bus.id_valid, 1);
        check("t5 new pc",    bus.id_pc,    16'h0080);
        tick();
        drive(16'h0084, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t5 empty", bus.id_valid, 0);
        tick();

        // 6: asynchronous reset mid-stream, then a clean fetch from 0.
        drive(16'h0060, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
        drive(16'h0064, 1'b1, 1'b1, 16'h0060, 1'b0, 1'b0); tick();
        drive(16'h0068, 1'b1, 1'b1, 16'h0064, 1'b0, 1'b0); tick();
        drive(16'h006C, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t6 valid pre", bus.id_valid, 1);
        check("t6 pc pre",    bus.id_pc,    16'h0060);
        check("t6 req pre",   bus.imem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6 async req",   bus.imem_req, 0);
        check("t6 async pc_en", bus.pc_en,    0);
        check("t6 async valid", bus.id_valid, 0);
        check("t6 async pc",    bus.id_pc,    0);
        check("t6 async instr", bus.id_instr, 0);
        tick();
        tick();
        rst = 1'b1;
        drive(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t6 req post",   bus.imem_req,  1);
        check("t6 pc_en post", bus.pc_en,     1);
        check("t6 addr post",  bus.imem_addr, 16'h0000);
        tick();
        drive(16'h0004, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0); tick();
        drive(16'h0004, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t6 valid post", bus.id_valid, 1);
        check("t6 pc post",    bus.id_pc,    16'h0000);
        check("t6 instr post", bus.id_instr, ins(16'h0000));
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
